load_store_queue: RTL and testbench
===================================

LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 DEPTH, 8, queue entries; power of two, >=2.
REQ-002 ROB_W, 4, ROB index width.
REQ-003 IO_BASE, 32'h0003_0000, addresses >= this are IO and never issue early.
REQ-004 clk_in  input  1  single clock; rising edge.
REQ-005 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 rdy_in  input  1  global enable; when 0, no state changes.
REQ-007 flush_in  input  1  mispredict flush.
REQ-008 in_valid/in_op/in_robid  input  1/6/ROB_W  dispatch of one memory instruction.
REQ-009 in_q1_busy/in_q2_busy, in_q1/in_q2, in_v1/in_v2, in_imm  input  1,1/ROB_W,ROB_W/32,32/32  operand tags, values and immediate.
REQ-010 full  output  1  asserted when count == DEPTH.
REQ-011 cdb_a_valid/cdb_a_robid/cdb_a_val  input  1/ROB_W/32  ALU broadcast.
REQ-012 mem_req/mem_store/mem_op/mem_addr/mem_data  output  1/1/6/32/32  memory request, held until mem_done.
REQ-013 mem_done/mem_rdata  input  1/32  memory completion pulse and load data.
REQ-014 rob_head_valid/rob_head_id  input  1/ROB_W  oldest uncommitted ROB entry.
REQ-015 out_valid/out_robid/out_val  output  1/ROB_W/32  one-cycle completion broadcast, also snooped internally.

Function
REQ-016 The queue SHALL be a circular FIFO with head, tail and a separate count; all DEPTH entries usable; wrap modulo DEPTH.
REQ-017 Enqueue SHALL occur when in_valid && !full; simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-018 Operands SHALL capture same-cycle cdb_a or out broadcast matching in_q1/in_q2 (cdb_a has priority); a captured tag SHALL be marked ready.
REQ-019 Every cycle, each valid entry SHALL snoop cdb_a and out, clearing busy tags and latching values.
REQ-020 Only the head entry SHALL issue; issue requires both operands ready; address = v1 + imm (32-bit wrap), data = v2.
REQ-021 A store, or a load with address >= IO_BASE, SHALL issue only when rob_head_valid && rob_head_id == entry robid.
REQ-022 FSM states IDLE, LOAD, STORE, DRAIN; IDLE->LOAD/STORE on issue (head advances same cycle), LOAD/STORE->IDLE on mem_done.
REQ-023 On mem_done in LOAD, the block SHALL drive out_valid=1, out_val=mem_rdata for one cycle; in STORE, out_valid=1, out_val=0.
REQ-024 mem_req SHALL rise on issue and fall on the cycle after mem_done; out_valid SHALL be 0 in all other cycles.
REQ-025 flush_in SHALL empty the queue (head=tail, count=0) the next cycle and suppress out_valid.
REQ-026 Flush while state is LOAD SHALL move to DRAIN; DRAIN holds mem_req until mem_done, discards data, then IDLE; no issue in DRAIN.
REQ-027 Flush while state is STORE SHALL keep STORE (committed store completes) but suppress out_valid.
REQ-028 Enqueue in the flush cycle SHALL be dropped.

Reset
REQ-029 rst_n_in low SHALL immediately clear head, tail, count, all entry valids, state=IDLE, mem_req=0, mem_store=0, mem_op=0, mem_addr=0, mem_data=0, out_valid=0, out_robid=0, out_val=0; full=0.
REQ-030 Reset mid-transaction SHALL abandon the transaction without waiting for mem_done.

Configuration
REQ-031 LSQ_EARLY_LOAD_EN defined: a non-IO head load SHALL issue without waiting for ROB head; undefined: all loads obey REQ-021.

Structure
REQ-032 Op encodings (Lb..Lhu, Sb..Sw), ROB_W, IO_BASE default and FSM state encodings SHALL reside in the shared const package.
REQ-033 No sub-module; an optional lsq_entry_snoop helper for per-entry tag match is permitted.

Verification
REQ-034 Fill DEPTH=8 with stores, no dispatch stall until count 8 -> full=1; one dequeue plus one enqueue keeps full=1.
REQ-035 Load x1=0x100 ready, imm=4, early-load on, rob_head_id differs -> mem_req=1, mem_addr=0x104; mem_done rdata=0xDEAD -> out_val=0xDEAD one cycle.
REQ-036 Load to 0x30000 -> no mem_req until rob_head_id matches.
REQ-037 Store with q2 busy tag 3, cdb_a robid 3 val 0x55 same cycle as enqueue -> mem_data=0x55 at issue.
REQ-038 Flush during LOAD -> DRAIN, queue empty, mem_done produces no out_valid, next load issues after IDLE.
REQ-039 Assert rst_n_in low mid-STORE -> mem_req=0 immediately, count=0.

Source files
------------

// File: rtl/load_store_queue_pkg.sv
// Shared constants for the load/store queue: op encodings, sizing defaults, FSM states.
package load_store_queue_pkg;

    localparam int          LSQ_DEPTH   = 8;
    localparam int          LSQ_ROB_W   = 4;
    localparam logic [31:0] LSQ_IO_BASE = 32'h0003_0000;

    localparam logic [5:0] OP_LB  = 6'd0;
    localparam logic [5:0] OP_LH  = 6'd1;
    localparam logic [5:0] OP_LW  = 6'd2;
    localparam logic [5:0] OP_LBU = 6'd3;
    localparam logic [5:0] OP_LHU = 6'd4;
    localparam logic [5:0] OP_SB  = 6'd8;
    localparam logic [5:0] OP_SH  = 6'd9;
    localparam logic [5:0] OP_SW  = 6'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2,
        ST_DRAIN = 2'd3
    } lsq_state_e;

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/load_store_queue_snoop.sv
// One operand's tag match against two result buses; bus A wins when both hit.
module load_store_queue_snoop #(
    parameter int ROB_W = 4
) (
    input  logic             busy_i,
    input  logic [ROB_W-1:0] tag_i,
    input  logic [31:0]      val_i,
    input  logic             a_valid_i,
    input  logic [ROB_W-1:0] a_tag_i,
    input  logic [31:0]      a_val_i,
    input  logic             b_valid_i,
    input  logic [ROB_W-1:0] b_tag_i,
    input  logic [31:0]      b_val_i,
    output logic             busy_o,
    output logic [31:0]      val_o
);
    logic a_hit, b_hit;

    assign a_hit  = busy_i && a_valid_i && (a_tag_i == tag_i);
    assign b_hit  = busy_i && b_valid_i && (b_tag_i == tag_i);
    assign busy_o = busy_i && !a_hit && !b_hit;
    assign val_o  = a_hit ? a_val_i : (b_hit ? b_val_i : val_i);
endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue issuing one memory op at a time from the head.
// Build option: LSQ_EARLY_LOAD_EN lets non-IO loads issue before reaching ROB head.
module load_store_queue
    import load_store_queue_pkg::*;
#(
    parameter int          DEPTH   = LSQ_DEPTH,
    parameter int          ROB_W   = LSQ_ROB_W,
    parameter logic [31:0] IO_BASE = LSQ_IO_BASE
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    input  logic [5:0]       in_op,
    input  logic [ROB_W-1:0] in_robid,
    input  logic             in_q1_busy,
    input  logic             in_q2_busy,
    input  logic [ROB_W-1:0] in_q1,
    input  logic [ROB_W-1:0] in_q2,
    input  logic [31:0]      in_v1,
    input  logic [31:0]      in_v2,
    input  logic [31:0]      in_imm,
    output logic             full,
    input  logic             cdb_a_valid,
    input  logic [ROB_W-1:0] cdb_a_robid,
    input  logic [31:0]      cdb_a_val,
    output logic             mem_req,
    output logic             mem_store,
    output logic [5:0]       mem_op,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_data,
    input  logic             mem_done,
    input  logic [31:0]      mem_rdata,
    input  logic             rob_head_valid,
    input  logic [ROB_W-1:0] rob_head_id,
    output logic             out_valid,
    output logic [ROB_W-1:0] out_robid,
    output logic [31:0]      out_val
);
    localparam int PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;
`ifdef LSQ_EARLY_LOAD_EN
    localparam bit EARLY_LOAD = 1'b1;
`else
    localparam bit EARLY_LOAD = 1'b0;
`endif

    lsq_state_e state_q, state_d;
    ptr_t       head_q, tail_q;
    logic [PW:0] cnt_q, cnt_d;

    logic [DEPTH-1:0]             vld_q, b1_q, b2_q, b1_s, b2_s;
    logic [DEPTH-1:0][5:0]        op_q;
    logic [DEPTH-1:0][ROB_W-1:0]  rob_q, t1_q, t2_q;
    logic [DEPTH-1:0][31:0]       v1_q, v2_q, imm_q, v1_s, v2_s;

    logic             eb1, eb2;
    logic [31:0]      ev1, ev2;
    logic             mem_req_q, mem_store_q, out_valid_q, out_valid_d, sup_q;
    logic [5:0]       mem_op_q;
    logic [31:0]      mem_addr_q, mem_data_q, out_val_q;
    logic [ROB_W-1:0] mem_rob_q, out_robid_q;

    logic        head_rdy, head_st, need_commit, commit_ok, issue, enq, done;
    logic [31:0] head_addr;

    // Dispatch-time capture and per-entry snoop share the same match logic;
    // the internal completion bus is snooped alongside cdb_a.
    load_store_queue_snoop #(.ROB_W(ROB_W)) u_enq1 (
        .busy_i(in_q1_busy), .tag_i(in_q1), .val_i(in_v1),
        .a_valid_i(cdb_a_valid), .a_tag_i(cdb_a_robid), .a_val_i(cdb_a_val),
        .b_valid_i(out_valid_q), .b_tag_i(out_robid_q), .b_val_i(out_val_q),
        .busy_o(eb1), .val_o(ev1));
    load_store_queue_snoop #(.ROB_W(ROB_W)) u_enq2 (
        .busy_i(in_q2_busy), .tag_i(in_q2), .val_i(in_v2),
        .a_valid_i(cdb_a_valid), .a_tag_i(cdb_a_robid), .a_val_i(cdb_a_val),
        .b_valid_i(out_valid_q), .b_tag_i(out_robid_q), .b_val_i(out_val_q),
        .busy_o(eb2), .val_o(ev2));

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        load_store_queue_snoop #(.ROB_W(ROB_W)) u_s1 (
            .busy_i(b1_q[e]), .tag_i(t1_q[e]), .val_i(v1_q[e]),
            .a_valid_i(cdb_a_valid), .a_tag_i(cdb_a_robid), .a_val_i(cdb_a_val),
            .b_valid_i(out_valid_q), .b_tag_i(out_robid_q), .b_val_i(out_val_q),
            .busy_o(b1_s[e]), .val_o(v1_s[e]));
        load_store_queue_snoop #(.ROB_W(ROB_W)) u_s2 (
            .busy_i(b2_q[e]), .tag_i(t2_q[e]), .val_i(v2_q[e]),
            .a_valid_i(cdb_a_valid), .a_tag_i(cdb_a_robid), .a_val_i(cdb_a_val),
            .b_valid_i(out_valid_q), .b_tag_i(out_robid_q), .b_val_i(out_val_q),
            .busy_o(b2_s[e]), .val_o(v2_s[e]));
    end

    assign full        = (cnt_q == (PW+1)'(DEPTH));
    assign head_rdy    = vld_q[head_q] && !b1_q[head_q] && !b2_q[head_q];
    assign head_st     = is_store_op(op_q[head_q]);
    assign head_addr   = v1_q[head_q] + imm_q[head_q];
    assign need_commit = head_st || (head_addr >= IO_BASE) || !EARLY_LOAD;
    assign commit_ok   = rob_head_valid && (rob_head_id == rob_q[head_q]);
    // A flush cycle never issues: the head belongs to the squashed path.
    assign issue       = rdy_in && !flush_in && (state_q == ST_IDLE) && head_rdy &&
                         (!need_commit || commit_ok);
    assign enq         = rdy_in && !flush_in && in_valid && !full;
    assign done        = rdy_in && mem_done && (state_q != ST_IDLE);
    assign out_valid_d = done && !flush_in && !sup_q &&
                         ((state_q == ST_LOAD) || (state_q == ST_STORE));
    assign cnt_d       = flush_in ? '0 : cnt_q + (PW+1)'(enq) - (PW+1)'(issue);

    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            case (state_q)
                ST_IDLE:  if (issue) state_d = head_st ? ST_STORE : ST_LOAD;
                ST_LOAD:  if (mem_done) state_d = ST_IDLE;
                          else if (flush_in) state_d = ST_DRAIN;
                ST_STORE: if (mem_done) state_d = ST_IDLE;
                ST_DRAIN: if (mem_done) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            vld_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_store_q <= 1'b0;
            mem_op_q    <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_rob_q   <= '0;
            out_valid_q <= 1'b0;
            out_robid_q <= '0;
            out_val_q   <= '0;
            sup_q       <= 1'b0;
        end else if (rdy_in) begin
            cnt_q <= cnt_d;
            if (flush_in) begin
                head_q <= '0;
                tail_q <= '0;
                vld_q  <= '0;
            end else begin
                if (enq)   tail_q <= tail_q + ptr_t'(1);
                if (issue) head_q <= head_q + ptr_t'(1);
                for (int e = 0; e < DEPTH; e++) begin
                    if (enq && tail_q == ptr_t'(e))        vld_q[e] <= 1'b1;
                    else if (issue && head_q == ptr_t'(e)) vld_q[e] <= 1'b0;
                end
            end
            if (issue) begin
                mem_req_q   <= 1'b1;
                mem_store_q <= head_st;
                mem_op_q    <= op_q[head_q];
                mem_addr_q  <= head_addr;
                mem_data_q  <= v2_q[head_q];
                mem_rob_q   <= rob_q[head_q];
            end else if (done) begin
                mem_req_q   <= 1'b0;
            end
            out_valid_q <= out_valid_d;
            if (out_valid_d) begin
                out_robid_q <= mem_rob_q;
                out_val_q   <= (state_q == ST_LOAD) ? mem_rdata : '0;
            end
            // A committed store survives a flush but its completion must not broadcast.
            if (done)                                  sup_q <= 1'b0;
            else if (flush_in && state_q == ST_STORE)  sup_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (enq && tail_q == ptr_t'(e)) begin
                    op_q[e]  <= in_op;
                    rob_q[e] <= in_robid;
                    t1_q[e]  <= in_q1;
                    t2_q[e]  <= in_q2;
                    imm_q[e] <= in_imm;
                    b1_q[e]  <= eb1;
                    b2_q[e]  <= eb2;
                    v1_q[e]  <= ev1;
                    v2_q[e]  <= ev2;
                end else begin
                    b1_q[e]  <= b1_s[e];
                    b2_q[e]  <= b2_s[e];
                    v1_q[e]  <= v1_s[e];
                    v2_q[e]  <= v2_s[e];
                end
            end
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_store = mem_store_q;
    assign mem_op    = mem_op_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign out_valid = out_valid_q;
    assign out_robid = out_robid_q;
    assign out_val   = out_val_q;
endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: fill/full, early vs IO loads, operand capture,
// flush in LOAD/STORE, rdy stall and asynchronous reset mid-store.
module tb_load_store_queue;
    import load_store_queue_pkg::*;

`ifdef LSQ_EARLY_LOAD_EN
    localparam logic EARLY = 1'b1;
`else
    localparam logic EARLY = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, flush_in, in_valid;
    logic [5:0]  in_op;
    logic [3:0]  in_robid, in_q1, in_q2, cdb_a_robid, rob_head_id, out_robid;
    logic        in_q1_busy, in_q2_busy, full, cdb_a_valid, rob_head_valid;
    logic [31:0] in_v1, in_v2, in_imm, cdb_a_val, mem_addr, mem_data, mem_rdata, out_val;
    logic        mem_req, mem_store, mem_done, out_valid;
    logic [5:0]  mem_op;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    load_store_queue dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_op(in_op), .in_robid(in_robid),
        .in_q1_busy(in_q1_busy), .in_q2_busy(in_q2_busy), .in_q1(in_q1), .in_q2(in_q2),
        .in_v1(in_v1), .in_v2(in_v2), .in_imm(in_imm), .full(full),
        .cdb_a_valid(cdb_a_valid), .cdb_a_robid(cdb_a_robid), .cdb_a_val(cdb_a_val),
        .mem_req(mem_req), .mem_store(mem_store), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .rob_head_valid(rob_head_valid), .rob_head_id(rob_head_id),
        .out_valid(out_valid), .out_robid(out_robid), .out_val(out_val));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [3:0] rob, input logic [31:0] v1,
                         input logic [31:0] imm, input logic [31:0] v2,
                         input logic b1, input logic [3:0] t1,
                         input logic b2, input logic [3:0] t2);
        in_valid = 1'b1; in_op = op; in_robid = rob;
        in_v1 = v1; in_imm = imm; in_v2 = v2;
        in_q1_busy = b1; in_q1 = t1; in_q2_busy = b2; in_q2 = t2;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0;
        in_op = '0; in_robid = '0; in_q1 = '0; in_q2 = '0; in_q1_busy = 1'b0; in_q2_busy = 1'b0;
        in_v1 = '0; in_v2 = '0; in_imm = '0; cdb_a_valid = 1'b0; cdb_a_robid = '0; cdb_a_val = '0;
        mem_done = 1'b0; mem_rdata = '0; rob_head_valid = 1'b0; rob_head_id = '0;

        #12;
        chk("rst_full", full, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_op", mem_op, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_robid", out_robid, 0);
        @(negedge clk_in) rst_n_in = 1'b1;
        step();

        // Fill with stores; none may issue while rob_head_valid is low.
        for (int i = 0; i < 8; i++) begin
            drive(OP_SW, 4'(i), 32'h200 + 32'(i * 4), 32'h0, 32'hA0 + 32'(i), 0, 0, 0, 0);
            step();
            if (i == 6) chk("full_at_7", full, 0);
        end
        in_valid = 1'b0;
        chk("full_at_8", full, 1);
        chk("no_issue_uncommitted", mem_req, 0);

        rob_head_valid = 1'b1; rob_head_id = 4'd0;
        step();
        chk("st0_req", mem_req, 1);
        chk("st0_addr", mem_addr, 32'h200);
        chk("st0_data", mem_data, 32'hA0);
        chk("st0_store", mem_store, 1);
        chk("full_after_deq", full, 0);

        mem_done = 1'b1; rob_head_valid = 1'b0;
        drive(OP_SW, 4'd8, 32'h220, 32'h0, 32'hA8, 0, 0, 0, 0);
        step();
        mem_done = 1'b0; in_valid = 1'b0;
        chk("full_after_refill", full, 1);
        chk("st0_out_valid", out_valid, 1);
        chk("st0_out_robid", out_robid, 0);
        chk("st0_out_val", out_val, 0);
        chk("st0_req_fall", mem_req, 0);

        rob_head_valid = 1'b1; rob_head_id = 4'd1;
        step();
        chk("st1_addr", mem_addr, 32'h204);
        chk("st1_data", mem_data, 32'hA1);
        chk("out_valid_pulse", out_valid, 0);

        // Flush while a committed store is outstanding, with a dispatch in the same cycle.
        flush_in = 1'b1; rob_head_valid = 1'b0;
        drive(OP_SW, 4'd9, 32'h300, 32'h0, 32'hB9, 0, 0, 0, 0);
        step();
        flush_in = 1'b0; in_valid = 1'b0;
        chk("flush_full", full, 0);
        chk("flush_store_req_held", mem_req, 1);
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        chk("flush_store_no_out", out_valid, 0);
        chk("flush_store_req_fall", mem_req, 0);
        rob_head_valid = 1'b1; rob_head_id = 4'd9;
        step(); step();
        chk("flush_drops_enq", mem_req, 0);

        // Non-IO load: early issue only in the early-load build.
        rob_head_id = 4'd5;
        drive(OP_LW, 4'd2, 32'h100, 32'h4, 32'h0, 0, 0, 0, 0);
        step();
        in_valid = 1'b0;
        step();
        chk("load_early", mem_req, EARLY);
        rob_head_id = 4'd2;
        step();
        chk("ld_req", mem_req, 1);
        chk("ld_addr", mem_addr, 32'h104);
        chk("ld_store", mem_store, 0);
        chk("ld_op", mem_op, OP_LW);
        mem_done = 1'b1; mem_rdata = 32'hDEAD;
        step();
        mem_done = 1'b0;
        chk("ld_out_valid", out_valid, 1);
        chk("ld_out_val", out_val, 32'hDEAD);
        chk("ld_out_robid", out_robid, 2);
        chk("ld_req_fall", mem_req, 0);
        step();
        chk("ld_out_one_cycle", out_valid, 0);

        // IO load waits for ROB head in every build.
        rob_head_id = 4'd5;
        drive(OP_LW, 4'd3, 32'h30000, 32'h0, 32'h0, 0, 0, 0, 0);
        step();
        in_valid = 1'b0;
        step(); step();
        chk("io_wait", mem_req, 0);
        rob_head_id = 4'd3;
        step();
        chk("io_req", mem_req, 1);
        chk("io_addr", mem_addr, 32'h30000);
        mem_done = 1'b1; mem_rdata = 32'h1234;
        step();
        mem_done = 1'b0;
        chk("io_out_val", out_val, 32'h1234);
        step();

        // Store whose data tag is broadcast on cdb_a in the dispatch cycle.
        rob_head_id = 4'd4;
        drive(OP_SW, 4'd4, 32'h40, 32'h8, 32'h0, 0, 0, 1, 4'd3);
        cdb_a_valid = 1'b1; cdb_a_robid = 4'd3; cdb_a_val = 32'h55;
        step();
        cdb_a_valid = 1'b0; in_valid = 1'b0; in_q2_busy = 1'b0;
        step();
        chk("cap_req", mem_req, 1);
        chk("cap_data", mem_data, 32'h55);
        chk("cap_addr", mem_addr, 32'h48);
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        chk("st_out_valid", out_valid, 1);
        chk("st_out_val", out_val, 0);
        chk("st_out_robid", out_robid, 4);

        // Flush during LOAD: drain without broadcast.
        rob_head_id = 4'd6;
        drive(OP_LW, 4'd6, 32'h600, 32'h0, 32'h0, 0, 0, 0, 0);
        step();
        drive(OP_LW, 4'd7, 32'h800, 32'h0, 32'h0, 0, 0, 0, 0);
        step();
        in_valid = 1'b0;
        chk("drain_ld_addr", mem_addr, 32'h600);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        chk("drain_holds_req", mem_req, 1);
        mem_done = 1'b1; mem_rdata = 32'hBEEF;
        step();
        mem_done = 1'b0;
        chk("drain_no_out", out_valid, 0);
        chk("drain_req_fall", mem_req, 0);
        rob_head_id = 4'd7;
        step(); step();
        chk("drain_queue_empty", mem_req, 0);

        // Entry operand woken by a later cdb_a broadcast.
        rob_head_id = 4'd8;
        drive(OP_LW, 4'd8, 32'h0, 32'h10, 32'h0, 1, 4'd9, 0, 0);
        step();
        in_valid = 1'b0; in_q1_busy = 1'b0;
        step();
        chk("snoop_wait", mem_req, 0);
        cdb_a_valid = 1'b1; cdb_a_robid = 4'd9; cdb_a_val = 32'h700;
        step();
        cdb_a_valid = 1'b0;
        chk("snoop_latch_only", mem_req, 0);
        step();
        chk("snoop_req", mem_req, 1);
        chk("snoop_addr", mem_addr, 32'h710);
        mem_done = 1'b1; mem_rdata = 32'h77;
        step();
        mem_done = 1'b0;
        chk("snoop_out_val", out_val, 32'h77);
        step();

        // rdy_in low freezes everything.
        rob_head_id = 4'd11;
        drive(OP_SW, 4'd11, 32'h50, 32'h0, 32'h11, 0, 0, 0, 0);
        step();
        in_valid = 1'b0; rdy_in = 1'b0;
        step(); step();
        chk("rdy_hold", mem_req, 0);
        rdy_in = 1'b1;
        step();
        chk("rdy_issue", mem_req, 1);
        chk("rdy_addr", mem_addr, 32'h50);

        // Asynchronous reset in the middle of the store.
        #2 rst_n_in = 1'b0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_full", full, 0);
        #2 rst_n_in = 1'b1;
        step(); step();
        chk("arst_queue_empty", mem_req, 0);
        rob_head_id = 4'd12;
        drive(OP_SW, 4'd12, 32'h60, 32'h0, 32'h0, 0, 0, 0, 0);
        step();
        in_valid = 1'b0;
        step();
        chk("arst_idle_issue", mem_req, 1);
        chk("arst_idle_addr", mem_addr, 32'h60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
